// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline stage register/control fields in,
// pipeline enables/flushes, forwarding selects and status out.
//   master : pipeline datapath side (drives stage info, sees control)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [4:0]       ex_rn;
  logic [4:0]       ex_rm;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm,
           ex_rn, ex_rm, ex_rd, ex_regwrite, ex_memread, ex_branch_taken,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
           fwd_a, fwd_b, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm,
           ex_rn, ex_rm, ex_rd, ex_regwrite, ex_memread, ex_branch_taken,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
           fwd_a, fwd_b, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline: load-use bubble,
// taken-branch squash, EX operand forwarding, dmem-busy freeze with sticky
// timeout error, and saturating stall/flush counters.
// Ports:
//   CLK    : clock, rising edge
//   resetl : synchronous active-low reset
//   hz     : controller side of pipeline_hazard_ctrl_if (stage info in,
//            enables/flush/bubble/hold, fwd_a/fwd_b, mem_err, counters out)
// Control outputs are combinational so they act on the same clock edge.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  resetl,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned        BUSY_W    = 8;
  localparam logic [BUSY_W-1:0]  BUSY_LAST = BUSY_W'(MEM_TIMEOUT - 1);
  localparam logic [4:0]         XZR       = 5'd31;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

  state_t             state, state_nxt;
  logic [BUSY_W-1:0]  busy_cnt, busy_cnt_nxt;
  logic               mem_err, mem_err_nxt;
  logic [CNT_W-1:0]   stall_cycles, flush_count;

  logic               lu_c;
  logic               flush_apply_c;
  logic               pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;
  logic [1:0]         fwd_a_c, fwd_b_c;

  // ex_regwrite carries no hazard information for this controller
  logic               unused_ok;
  assign unused_ok = hz.ex_regwrite;

  // Forwarding select for one EX source; MEM beats WB, XZR never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       m_we, input logic [4:0] m_rd,
                                         input logic       w_we, input logic [4:0] w_rd);
    if (m_we && (m_rd != XZR) && (m_rd == src))      return 2'b10;
    else if (w_we && (w_rd != XZR) && (w_rd == src)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  // Load in EX whose destination feeds the ID instruction
  assign lu_c = hz.ex_memread && (hz.ex_rd != XZR) &&
                ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                 (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));

  // Prioritised pipeline control
  always_comb begin
    pc_write_c    = 1'b0;
    ifid_write_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_hold_c   = 1'b0;
    flush_apply_c = 1'b0;
    fwd_a_c       = 2'b00;
    fwd_b_c       = 2'b00;
    if (!resetl) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else begin
      fwd_a_c = fwd_sel(hz.ex_rn, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
      fwd_b_c = fwd_sel(hz.ex_rm, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
      if ((state == ST_ERR) || hz.dmem_busy) begin
        // freeze: pending branch/load-use replays once memory is ready
        pipe_hold_c = 1'b1;
      end else if (hz.ex_branch_taken) begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        flush_apply_c = 1'b1;
      end else if (lu_c) begin
        idex_bubble_c = 1'b1;
      end else begin
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
      end
    end
  end

  // Memory-wait tracking: RUN -> WAIT on busy, ERR after MEM_TIMEOUT busy cycles
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      ST_RUN: begin
        if (hz.dmem_busy) begin
          state_nxt    = ST_WAIT;
          busy_cnt_nxt = BUSY_W'(1);
        end
      end
      ST_WAIT: begin
        if (!hz.dmem_busy) begin
          state_nxt    = ST_RUN;
          busy_cnt_nxt = '0;
        end else if (busy_cnt == BUSY_LAST) begin
          state_nxt   = ST_ERR;
          mem_err_nxt = 1'b1;
        end else begin
          busy_cnt_nxt = busy_cnt + BUSY_W'(1);
        end
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_RUN;
    endcase
  end

  // State, sticky error and saturating counters
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state        <= ST_RUN;
      busy_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      mem_err  <= mem_err_nxt;
      if (!pc_write_c && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_apply_c && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.ifid_write   = ifid_write_c;
  assign hz.ifid_flush   = ifid_flush_c;
  assign hz.idex_bubble  = idex_bubble_c;
  assign hz.pipe_hold    = pipe_hold_c;
  assign hz.fwd_a        = fwd_a_c;
  assign hz.fwd_b        = fwd_b_c;
  assign hz.mem_err      = mem_err;
  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_count  = flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: single-cycle vector table
// plus hand-written multi-cycle sequences (load-use, busy freeze, timeout,
// counter saturation with a narrow counter width).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic CLK = 1'b0;
  logic resetl = 1'b0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .hz     (hz.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  typedef struct {
    logic [4:0] id_rn, id_rm;
    logic       uses_rn, uses_rm;
    logic [4:0] ex_rn, ex_rm, ex_rd;
    logic       memread, br;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       e_pc, e_ifid, e_flush, e_bub;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    else passes++;
  endtask

  function automatic vec_t vdef();
    vec_t v;
    v.id_rn = 5'd1;  v.id_rm = 5'd2;  v.uses_rn = 1'b0; v.uses_rm = 1'b0;
    v.ex_rn = 5'd10; v.ex_rm = 5'd11; v.ex_rd = 5'd12;
    v.memread = 1'b0; v.br = 1'b0;
    v.mem_rd = 5'd20; v.mem_rw = 1'b0; v.wb_rd = 5'd21; v.wb_rw = 1'b0;
    v.e_pc = 1'b1; v.e_ifid = 1'b1; v.e_flush = 1'b0; v.e_bub = 1'b0;
    v.e_fa = 2'b00; v.e_fb = 2'b00;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic busy);
    hz.id_rn = v.id_rn; hz.id_rm = v.id_rm;
    hz.id_uses_rn = v.uses_rn; hz.id_uses_rm = v.uses_rm;
    hz.ex_rn = v.ex_rn; hz.ex_rm = v.ex_rm; hz.ex_rd = v.ex_rd;
    hz.ex_regwrite = 1'b1; hz.ex_memread = v.memread; hz.ex_branch_taken = v.br;
    hz.mem_rd = v.mem_rd; hz.mem_regwrite = v.mem_rw;
    hz.wb_rd = v.wb_rd; hz.wb_regwrite = v.wb_rw;
    hz.dmem_busy = busy;
  endtask

  // Counter check at the start of a cycle against the model so far
  task automatic next_cycle(input string tag);
    @(negedge CLK);
    chk({tag, "_stall_cnt"}, 32'(hz.stall_cycles), 32'(exp_stall));
    chk({tag, "_flush_cnt"}, 32'(hz.flush_count),  32'(exp_flush));
  endtask

  // Control-output check mid-cycle; advances the counter model
  task automatic ctl(input string tag, input logic pc, input logic ifid,
                     input logic fl, input logic bub, input logic hold);
    #1;
    chk({tag, "_pc_write"},    32'(hz.pc_write),    32'(pc));
    chk({tag, "_ifid_write"},  32'(hz.ifid_write),  32'(ifid));
    chk({tag, "_ifid_flush"},  32'(hz.ifid_flush),  32'(fl));
    chk({tag, "_idex_bubble"}, 32'(hz.idex_bubble), 32'(bub));
    chk({tag, "_pipe_hold"},   32'(hz.pipe_hold),   32'(hold));
    if (!resetl) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!pc && exp_stall != CMAX) exp_stall = exp_stall + CNT_W'(1);
      if (fl && pc && exp_flush != CMAX) exp_flush = exp_flush + CNT_W'(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // ---- table of single-cycle vectors (RUN state, memory ready) ----
    vecs[0] = vdef();
    v = vdef(); v.memread = 1; v.ex_rd = 5; v.uses_rn = 1; v.id_rn = 5;
      v.e_pc = 0; v.e_ifid = 0; v.e_bub = 1; vecs[1] = v;
    v = vdef(); v.memread = 1; v.ex_rd = 31; v.uses_rn = 1; v.id_rn = 31; vecs[2] = v;
    v = vdef(); v.memread = 1; v.ex_rd = 7; v.uses_rm = 1; v.id_rm = 7;
      v.e_pc = 0; v.e_ifid = 0; v.e_bub = 1; vecs[3] = v;
    v = vdef(); v.memread = 1; v.ex_rd = 5; v.uses_rn = 0; v.id_rn = 5; vecs[4] = v;
    v = vdef(); v.ex_rn = 3; v.mem_rd = 3; v.mem_rw = 1; v.wb_rd = 3; v.wb_rw = 1;
      v.e_fa = 2'b10; vecs[5] = v;
    v = vdef(); v.ex_rn = 3; v.mem_rd = 3; v.mem_rw = 0; v.wb_rd = 3; v.wb_rw = 1;
      v.e_fa = 2'b01; vecs[6] = v;
    v = vdef(); v.ex_rn = 3; v.wb_rd = 31; v.wb_rw = 1; vecs[7] = v;
    v = vdef(); v.ex_rn = 31; v.ex_rm = 31; v.mem_rd = 31; v.mem_rw = 1;
      v.wb_rd = 31; v.wb_rw = 1; vecs[8] = v;
    v = vdef(); v.ex_rn = 9; v.ex_rm = 9; v.mem_rd = 9; v.mem_rw = 1; v.wb_rd = 9; v.wb_rw = 1;
      v.e_fa = 2'b10; v.e_fb = 2'b10; vecs[9] = v;
    v = vdef(); v.br = 1; v.memread = 1; v.ex_rd = 5; v.uses_rn = 1; v.id_rn = 5;
      v.e_flush = 1; v.e_bub = 1; vecs[10] = v;
    v = vdef(); v.br = 1; v.ex_rm = 4; v.wb_rd = 4; v.wb_rw = 1;
      v.e_flush = 1; v.e_bub = 1; v.e_fb = 2'b01; vecs[11] = v;

    // ---- reset held two edges; forwarding suppressed during reset ----
    v = vdef(); v.ex_rn = 3; v.mem_rd = 3; v.mem_rw = 1;
    drive(v, 1'b0);
    resetl = 1'b0;
    ctl("rst0", 0, 0, 1, 1, 0);
    chk("rst0_fwd_a", 32'(hz.fwd_a), 32'd0);
    @(negedge CLK);
    ctl("rst1", 0, 0, 1, 1, 0);
    next_cycle("post_rst");
    drive(vdef(), 1'b0);
    resetl = 1'b1;
    ctl("run0", 1, 1, 0, 0, 0);
    chk("run0_mem_err", 32'(hz.mem_err), 32'd0);

    // ---- table loop ----
    for (int i = 0; i < NV; i++) begin
      next_cycle($sformatf("vec%0d", i));
      drive(vecs[i], 1'b0);
      ctl($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifid,
          vecs[i].e_flush, vecs[i].e_bub, 1'b0);
      chk($sformatf("vec%0d_fwd_a", i), 32'(hz.fwd_a), 32'(vecs[i].e_fa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(hz.fwd_b), 32'(vecs[i].e_fb));
    end

    // ---- load-use: one bubble, then load in MEM forwards to dependent in EX ----
    next_cycle("lu_a");
    v = vdef(); v.memread = 1; v.ex_rd = 6; v.uses_rm = 1; v.id_rm = 6;
    drive(v, 1'b0);
    ctl("lu_a", 0, 0, 0, 1, 0);
    next_cycle("lu_b");
    v = vdef(); v.ex_rm = 6; v.mem_rd = 6; v.mem_rw = 1;
    drive(v, 1'b0);
    ctl("lu_b", 1, 1, 0, 0, 0);
    chk("lu_b_fwd_b", 32'(hz.fwd_b), 32'b10);

    // ---- busy 3 cycles with taken branch pending, then flush ----
    v = vdef(); v.br = 1; v.ex_rn = 8; v.mem_rd = 8; v.mem_rw = 1;
    for (int c = 0; c < 3; c++) begin
      next_cycle($sformatf("busy3_%0d", c));
      drive(v, 1'b1);
      ctl($sformatf("busy3_%0d", c), 0, 0, 0, 0, 1);
      chk($sformatf("busy3_%0d_fwd_a", c), 32'(hz.fwd_a), 32'b10);
    end
    next_cycle("busy3_rel");
    drive(v, 1'b0);
    ctl("busy3_rel", 1, 1, 1, 1, 0);
    chk("busy3_rel_mem_err", 32'(hz.mem_err), 32'd0);

    // ---- busy 1 cycle with load-use pending: bubble deferred ----
    next_cycle("busylu_a");
    v = vdef(); v.memread = 1; v.ex_rd = 2; v.uses_rn = 1; v.id_rn = 2;
    drive(v, 1'b1);
    ctl("busylu_a", 0, 0, 0, 0, 1);
    next_cycle("busylu_b");
    drive(v, 1'b0);
    ctl("busylu_b", 0, 0, 0, 1, 0);

    // ---- timeout: busy 6 cycles, error from cycle 5, sticky after release ----
    for (int c = 1; c <= 6; c++) begin
      next_cycle($sformatf("tmo_%0d", c));
      drive(vdef(), 1'b1);
      ctl($sformatf("tmo_%0d", c), 0, 0, 0, 0, 1);
      chk($sformatf("tmo_%0d_mem_err", c), 32'(hz.mem_err), (c >= 5) ? 32'd1 : 32'd0);
    end
    next_cycle("tmo_rel");
    v = vdef(); v.br = 1;
    drive(v, 1'b0);
    ctl("tmo_rel", 0, 0, 0, 0, 1);
    chk("tmo_rel_mem_err", 32'(hz.mem_err), 32'd1);
    next_cycle("tmo_rst");
    drive(vdef(), 1'b0);
    resetl = 1'b0;
    ctl("tmo_rst", 0, 0, 1, 1, 0);
    next_cycle("tmo_run");
    resetl = 1'b1;
    ctl("tmo_run", 1, 1, 0, 0, 0);
    chk("tmo_run_mem_err", 32'(hz.mem_err), 32'd0);

    // ---- counter saturation ----
    v = vdef(); v.memread = 1; v.ex_rd = 5; v.uses_rn = 1; v.id_rn = 5;
    for (int c = 0; c < 18; c++) begin
      next_cycle($sformatf("satst_%0d", c));
      drive(v, 1'b0);
      ctl($sformatf("satst_%0d", c), 0, 0, 0, 1, 0);
    end
    v = vdef(); v.br = 1;
    for (int c = 0; c < 18; c++) begin
      next_cycle($sformatf("satfl_%0d", c));
      drive(v, 1'b0);
      ctl($sformatf("satfl_%0d", c), 1, 1, 1, 1, 0);
    end
    next_cycle("sat_end");
    chk("sat_end_stall_max", 32'(hz.stall_cycles), 32'(CMAX));
    chk("sat_end_flush_max", 32'(hz.flush_count),  32'(CMAX));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
